seven_seg_scanner: RTL and testbench

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

---
 rtl/seven_seg_scanner.sv | 189 ++++++++++++++++++
 tb/tb_seven_seg_scanner.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// Multiplexed hex seven-segment scanner with frame-synchronous display updates.
// Optional decimal-point support is enabled by defining SEVEN_SEG_DP_EN.
module seven_seg_scanner #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst_l,
  input  logic [4*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]   blank_mask,
  input  logic                load,
  input  logic                lz_blank,
`ifdef SEVEN_SEG_DP_EN
  input  logic [DIGITS-1:0]   dp,
  output logic                dp_n,
`endif
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   an,
  output logic                update_pending,
  output logic                frame_done
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0]    div_cnt;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] pend_value;
  logic [DIGITS-1:0]   pend_mask;
  logic [4*DIGITS-1:0] disp_value;
  logic [DIGITS-1:0]   disp_mask;

  logic                div_tc;
  logic                frame_edge;
  logic                take_input;
  logic                take_pend;

  logic [DIGITS:0]     zero_from;
  logic [3:0]          cur_nib;
  logic                cur_masked;
  logic                cur_lead_zero;
  logic                cur_dark;

`ifdef SEVEN_SEG_DP_EN
  logic [DIGITS-1:0]   pend_dp;
  logic [DIGITS-1:0]   disp_dp;
  logic                cur_dp;
`endif

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  assign div_tc     = (div_cnt == DIV_LAST);
  assign frame_edge = div_tc && (idx == IDX_LAST);
  assign take_input = frame_edge && load;
  assign take_pend  = frame_edge && !load && update_pending;

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      div_cnt    <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_edge;
      if (div_tc) begin
        div_cnt <= '0;
        idx     <= frame_edge ? '0 : idx + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // A load landing on the frame edge bypasses pending and goes straight to display.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      pend_value     <= '0;
      pend_mask      <= '0;
      disp_value     <= '0;
      disp_mask      <= '0;
      update_pending <= 1'b0;
    end else begin
      if (load) begin
        pend_value <= value;
        pend_mask  <= blank_mask;
      end
      if (take_input) begin
        disp_value     <= value;
        disp_mask      <= blank_mask;
        update_pending <= 1'b0;
      end else if (take_pend) begin
        disp_value     <= pend_value;
        disp_mask      <= pend_mask;
        update_pending <= 1'b0;
      end else if (load) begin
        update_pending <= 1'b1;
      end
    end
  end

`ifdef SEVEN_SEG_DP_EN
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      pend_dp <= '0;
      disp_dp <= '0;
    end else begin
      if (load) begin
        pend_dp <= dp;
      end
      if (take_input) begin
        disp_dp <= dp;
      end else if (take_pend) begin
        disp_dp <= pend_dp;
      end
    end
  end
`endif

  // zero_from[i] is set when nibble i and every nibble above it are zero.
  always_comb begin
    zero_from         = '0;
    zero_from[DIGITS] = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] && (disp_value[4*i +: 4] == 4'h0);
    end
  end

  always_comb begin
    cur_nib       = 4'h0;
    cur_masked    = 1'b0;
    cur_lead_zero = 1'b0;
`ifdef SEVEN_SEG_DP_EN
    cur_dp        = 1'b0;
`endif
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib       = disp_value[4*i +: 4];
        cur_masked    = disp_mask[i];
        cur_lead_zero = (i != 0) && zero_from[i];
`ifdef SEVEN_SEG_DP_EN
        cur_dp        = disp_dp[i];
`endif
      end
    end
  end

  assign cur_dark = cur_masked || (lz_blank && cur_lead_zero);

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      seg <= 7'h7F;
      an  <= '1;
    end else begin
      seg <= cur_dark ? 7'h7F : hex_to_seg(cur_nib);
      an  <= ~(DIGITS'(1) << idx);
    end
  end

`ifdef SEVEN_SEG_DP_EN
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      dp_n <= 1'b1;
    end else begin
      dp_n <= cur_dark ? 1'b1 : ~cur_dp;
    end
  end
`endif

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner (DIGITS=4, REFRESH_DIV=4): stimulus queues the
// expected digit sequence, a monitor pops one entry each time the lit digit changes.
module tb_seven_seg_scanner;

  localparam int DIGITS      = 4;
  localparam int REFRESH_DIV = 4;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       upd;
    logic       fdp;
    logic       dpn;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_l;
  logic [15:0] value;
  logic [3:0]  blank_mask;
  logic        load;
  logic        lz_blank;
  logic [3:0]  dp;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        update_pending;
  logic        frame_done;
`ifdef SEVEN_SEG_DP_EN
  logic        dp_n;
`endif

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b1;
  logic [3:0] prev_an = 4'bxxxx;
  logic       prev_fd = 1'b0;

  seven_seg_scanner #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) dut (
    .clk            (clk),
    .rst_l          (rst_l),
    .value          (value),
    .blank_mask     (blank_mask),
    .load           (load),
    .lz_blank       (lz_blank),
`ifdef SEVEN_SEG_DP_EN
    .dp             (dp),
    .dp_n           (dp_n),
`endif
    .seg            (seg),
    .an             (an),
    .update_pending (update_pending),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  function automatic void push(input logic [3:0] a, input logic [6:0] s, input logic u,
                               input logic f, input logic d);
    exp_t e;
    e.an = a; e.seg = s; e.upd = u; e.fdp = f; e.dpn = d;
    exp_q.push_back(e);
  endfunction

  task automatic checkOutput(input exp_t e, input logic fd_before);
    checks++;
    if (an !== e.an || seg !== e.seg || update_pending !== e.upd || fd_before !== e.fdp) begin
      errors++;
      $display("[TB] FAIL digit_scan: got an=%b seg=%h upd=%b fd_prev=%b, expected an=%b seg=%h upd=%b fd_prev=%b",
               an, seg, update_pending, fd_before, e.an, e.seg, e.upd, e.fdp);
    end
`ifdef SEVEN_SEG_DP_EN
    checks++;
    if (dp_n !== e.dpn) begin
      errors++;
      $display("[TB] FAIL dp_n: got %b expected %b (an=%b)", dp_n, e.dpn, an);
    end
`endif
  endtask

  task automatic applyStimulus(input logic [15:0] v, input logic [3:0] m, input logic [3:0] d);
    value      = v;
    blank_mask = m;
    dp         = d;
    load       = 1'b1;
    @(negedge clk);
    load       = 1'b0;
  endtask

  task automatic wait_an(input logic [3:0] target);
    int n = 0;
    while (an !== target && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (an !== target) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_an: got an=%b expected %b within 100 cycles", an, target);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (an !== prev_an) begin
        prev_an = an;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_digit: got an=%b seg=%h, expected no change", an, seg);
        end else begin
          checkOutput(exp_q.pop_front(), prev_fd);
        end
      end
      if (frame_done === 1'b1) begin
        checks++;
        if (prev_fd !== 1'b0 || an !== 4'b0111) begin
          errors++;
          $display("[TB] FAIL frame_done_pulse: got an=%b prev_fd=%b, expected an=0111 prev_fd=0",
                   an, prev_fd);
        end
      end
    end
    prev_fd = frame_done;
  end

  initial begin
    rst_l = 1'b0; value = '0; blank_mask = '0; load = 1'b0; lz_blank = 1'b0; dp = '0;

    $display("[TB] scan and decode of 12AF");
    push(4'b1111, 7'h7F, 0, 0, 1);
    push(4'b1110, 7'h40, 0, 0, 1);
    push(4'b1101, 7'h40, 1, 0, 1);
    push(4'b1011, 7'h40, 1, 0, 1);
    push(4'b0111, 7'h40, 1, 0, 1);
    push(4'b1110, 7'h0E, 0, 1, 1);
    push(4'b1101, 7'h08, 0, 0, 1);
    push(4'b1011, 7'h24, 0, 0, 1);
    push(4'b0111, 7'h79, 0, 0, 1);
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(16'h12AF, 4'b0000, 4'b0000);
    drain();

    $display("[TB] leading-zero blanking");
    push(4'b1110, 7'h40, 0, 1, 1);
    push(4'b1101, 7'h30, 0, 0, 1);
    push(4'b1011, 7'h7F, 0, 0, 1);
    push(4'b0111, 7'h7F, 0, 0, 1);
    lz_blank = 1'b1;
    applyStimulus(16'h0030, 4'b0000, 4'b0000);
    drain();
    push(4'b1110, 7'h40, 0, 1, 1);
    push(4'b1101, 7'h7F, 0, 0, 1);
    push(4'b1011, 7'h7F, 0, 0, 1);
    push(4'b0111, 7'h7F, 0, 0, 1);
    applyStimulus(16'h0000, 4'b0000, 4'b0000);
    drain();

    $display("[TB] blank mask");
    push(4'b1110, 7'h79, 0, 1, 1);
    push(4'b1101, 7'h24, 0, 0, 1);
    push(4'b1011, 7'h7F, 0, 0, 1);
    push(4'b0111, 7'h00, 0, 0, 1);
    lz_blank = 1'b0;
    applyStimulus(16'h8421, 4'b0100, 4'b0000);
    drain();

    $display("[TB] mid-frame load, last load wins");
    push(4'b1110, 7'h79, 0, 1, 1);
    push(4'b1101, 7'h24, 0, 0, 1);
    push(4'b1011, 7'h7F, 1, 0, 1);
    push(4'b0111, 7'h00, 1, 0, 1);
    push(4'b1110, 7'h12, 0, 1, 1);
    push(4'b1101, 7'h12, 0, 0, 1);
    push(4'b1011, 7'h12, 0, 0, 1);
    push(4'b0111, 7'h12, 0, 0, 1);
    wait_an(4'b1101);
    applyStimulus(16'h9999, 4'b0000, 4'b0000);
    applyStimulus(16'h5555, 4'b0000, 4'b0000);
    drain();

    $display("[TB] load coincident with frame boundary");
    push(4'b1110, 7'h12, 0, 1, 1);
    push(4'b1101, 7'h12, 0, 0, 1);
    push(4'b1011, 7'h12, 0, 0, 1);
    push(4'b0111, 7'h12, 0, 0, 1);
    push(4'b1110, 7'h0E, 0, 1, 1);
    push(4'b1101, 7'h06, 0, 0, 1);
    push(4'b1011, 7'h06, 0, 0, 1);
    push(4'b0111, 7'h03, 0, 0, 1);
    wait_an(4'b1110);
    wait_an(4'b0111);
    repeat (2) @(negedge clk);
    applyStimulus(16'hBEEF, 4'b0000, 4'b0000);
    drain();

    $display("[TB] reset mid-frame with pending data");
    push(4'b1110, 7'h0E, 0, 1, 1);
    push(4'b1101, 7'h06, 0, 0, 1);
    push(4'b1011, 7'h06, 1, 0, 1);
    push(4'b1111, 7'h7F, 0, 0, 1);
    push(4'b1110, 7'h40, 0, 0, 1);
    push(4'b1101, 7'h40, 0, 0, 1);
    push(4'b1011, 7'h40, 0, 0, 1);
    push(4'b0111, 7'h40, 0, 0, 1);
    wait_an(4'b1101);
    applyStimulus(16'h7777, 4'b0000, 4'b0000);
    wait_an(4'b1011);
    rst_l = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
    drain();

`ifdef SEVEN_SEG_DP_EN
    $display("[TB] decimal point");
    push(4'b1110, 7'h79, 0, 1, 1);
    push(4'b1101, 7'h24, 0, 0, 0);
    push(4'b1011, 7'h19, 0, 0, 1);
    push(4'b0111, 7'h00, 0, 0, 1);
    applyStimulus(16'h8421, 4'b0000, 4'b0010);
    drain();
    push(4'b1110, 7'h79, 0, 1, 1);
    push(4'b1101, 7'h7F, 0, 0, 1);
    push(4'b1011, 7'h19, 0, 0, 1);
    push(4'b0111, 7'h00, 0, 0, 1);
    applyStimulus(16'h8421, 4'b0010, 4'b0010);
    drain();
`endif

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
